// File: rtl/qea_host_sequencer.sv
// Host-side sequencer for QEA: loads gate context, clears state RAM to |0..0>,
// starts the core, times the run and streams amplitude rows back out.
module qea_host_sequencer #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int RD_LAT                  = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_cmd_start,
  input  logic [MAX_QBIT_WIDTH-1:0]              i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]     i_ins_num,
  input  logic                                   i_ctx_valid,
  output logic                                   o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]     i_ctx_data,
  output logic                                   o_amp_valid,
  input  logic                                   i_amp_ready,
  output logic                                   o_amp_last,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]     o_amp_data,
  output logic                                   o_busy,
  output logic                                   o_done,
  output logic                                   o_err,
  output logic [31:0]                            o_cycle_count,
  output logic                                   o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]              o_qea_qbit_num,
  output logic                                   o_ctx_en,
  output logic                                   o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]     o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]     o_ctx_data,
  output logic                                   o_state_ena,
  output logic                                   o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]            o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]     o_state_dina,
  input  logic                                   i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]     i_state_dout
);

  localparam int RW = PE_NUM*STATE_DATA_WIDTH;
  localparam int AW = STATE_ADDR_WIDTH;
  localparam int CW = GATE_CONTEXT_ADDR_WIDTH;
  localparam int QW = MAX_QBIT_WIDTH;
  localparam logic [QW-1:0] QMIN = QW'(PE_NUM_WIDTH);
  localparam logic [QW-1:0] QMAX = QW'(PE_NUM_WIDTH + STATE_ADDR_WIDTH);
  localparam logic [7:0] WL = 8'(RD_LAT - 1);
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  localparam logic [RW-1:0] ROW0 = {ONE, {(RW-DATA_WIDTH){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, LOAD_CTX, INIT_STATE, START,
    RUN, RD_REQ, RD_WAIT, RD_OUT
  } state_t;

  state_t state, state_d;

  logic [QW-1:0] qbit, qbit_d;
  logic [CW-1:0] ins, ins_d, k, k_d;
  logic [AW-1:0] last, last_d, r, r_d;
  logic [1:0]    mask, mask_d;
  logic [7:0]    wcnt, wcnt_d;
  logic [AW:0]   rows_w;
  logic          bad;

  logic          ctx_ready_d, ctx_en_d, ctx_wea_d;
  logic [CW-1:0] ctx_addr_d;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_d;
  logic          st_ena_d, st_wea_d;
  logic [AW-1:0] st_addr_d;
  logic [RW-1:0] st_din_d, amp_data_d;
  logic          amp_valid_d, amp_last_d;
  logic          busy_d, done_d, err_d, start_d;
  logic [31:0]   cnt_d;
  logic [QW-1:0] qnum_d;

  assign rows_w = (AW+1)'(1) << (i_qbit_num - QMIN);
  assign bad = (i_qbit_num <= QMIN) || (i_qbit_num > QMAX);

  always_comb begin
    state_d     = state;
    qbit_d      = qbit;
    ins_d       = ins;
    last_d      = last;
    k_d         = k;
    r_d         = r;
    mask_d      = mask;
    wcnt_d      = wcnt;
    ctx_en_d    = 1'b0;
    ctx_wea_d   = 1'b0;
    ctx_addr_d  = '0;
    ctx_data_d  = '0;
    st_ena_d    = 1'b0;
    st_wea_d    = 1'b0;
    st_addr_d   = '0;
    st_din_d    = '0;
    amp_valid_d = 1'b0;
    amp_last_d  = 1'b0;
    amp_data_d  = o_amp_data;
    done_d      = 1'b0;
    err_d       = 1'b0;
    start_d     = 1'b0;
    cnt_d       = o_cycle_count;

    unique case (state)
      IDLE: begin
        if (i_cmd_start) begin
          if (bad) begin
            err_d = 1'b1;
          end else begin
            qbit_d  = i_qbit_num;
            ins_d   = i_ins_num;
            last_d  = AW'(rows_w - (AW+1)'(1));
            k_d     = '0;
            r_d     = '0;
            state_d = (i_ins_num == '0) ? INIT_STATE : LOAD_CTX;
          end
        end
      end
      LOAD_CTX: begin
        if (i_ctx_valid && o_ctx_ready) begin
          ctx_en_d   = 1'b1;
          ctx_wea_d  = 1'b1;
          ctx_addr_d = k;
          ctx_data_d = i_ctx_data;
          if (k == ins - CW'(1)) begin
            k_d     = '0;
            state_d = INIT_STATE;
          end else begin
            k_d = k + CW'(1);
          end
        end
      end
      INIT_STATE: begin
        st_ena_d  = 1'b1;
        st_wea_d  = 1'b1;
        st_addr_d = r;
        st_din_d  = (r == '0) ? ROW0 : '0;
        if (r == last) begin
          r_d     = '0;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = START;
        end else begin
          r_d = r + AW'(1);
        end
      end
      START: begin
        cnt_d   = o_cycle_count + 32'd1;
        mask_d  = 2'd2;
        state_d = RUN;
      end
      RUN: begin
        if (o_cycle_count != '1) cnt_d = o_cycle_count + 32'd1;
        // complete may still be high from the previous job
        if (mask != '0) begin
          mask_d = mask - 2'd1;
        end else if (i_qea_complete) begin
          r_d       = '0;
          st_ena_d  = 1'b1;
          st_addr_d = '0;
          state_d   = RD_REQ;
        end
      end
      RD_REQ: begin
        wcnt_d  = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (wcnt == WL) begin
          amp_data_d  = i_state_dout;
          amp_valid_d = 1'b1;
          amp_last_d  = (r == last);
          state_d     = RD_OUT;
        end else begin
          wcnt_d = wcnt + 8'd1;
        end
      end
      RD_OUT: begin
        amp_valid_d = 1'b1;
        amp_last_d  = o_amp_last;
        if (i_amp_ready) begin
          amp_valid_d = 1'b0;
          amp_last_d  = 1'b0;
          if (r == last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            r_d       = r + AW'(1);
            st_ena_d  = 1'b1;
            st_addr_d = r + AW'(1);
            state_d   = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    qnum_d      = busy_d ? qbit_d : '0;
    ctx_ready_d = (state_d == LOAD_CTX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      qbit           <= '0;
      ins            <= '0;
      last           <= '0;
      k              <= '0;
      r              <= '0;
      mask           <= '0;
      wcnt           <= '0;
      o_ctx_ready    <= 1'b0;
      o_ctx_en       <= 1'b0;
      o_ctx_wea      <= 1'b0;
      o_ctx_addr     <= '0;
      o_ctx_data     <= '0;
      o_state_ena    <= 1'b0;
      o_state_wea    <= 1'b0;
      o_state_addra  <= '0;
      o_state_dina   <= '0;
      o_amp_valid    <= 1'b0;
      o_amp_last     <= 1'b0;
      o_amp_data     <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      o_qea_start    <= 1'b0;
      o_cycle_count  <= '0;
      o_qea_qbit_num <= '0;
    end else begin
      state          <= state_d;
      qbit           <= qbit_d;
      ins            <= ins_d;
      last           <= last_d;
      k              <= k_d;
      r              <= r_d;
      mask           <= mask_d;
      wcnt           <= wcnt_d;
      o_ctx_ready    <= ctx_ready_d;
      o_ctx_en       <= ctx_en_d;
      o_ctx_wea      <= ctx_wea_d;
      o_ctx_addr     <= ctx_addr_d;
      o_ctx_data     <= ctx_data_d;
      o_state_ena    <= st_ena_d;
      o_state_wea    <= st_wea_d;
      o_state_addra  <= st_addr_d;
      o_state_dina   <= st_din_d;
      o_amp_valid    <= amp_valid_d;
      o_amp_last     <= amp_last_d;
      o_amp_data     <= amp_data_d;
      o_busy         <= busy_d;
      o_done         <= done_d;
      o_err          <= err_d;
      o_qea_start    <= start_d;
      o_cycle_count  <= cnt_d;
      o_qea_qbit_num <= qnum_d;
    end
  end

endmodule
